// File: rtl/fdma_rd_ctrl.sv
// fdma_rd_ctrl: issues fixed-size DDR read bursts over a ring of
// buffers and streams the returned beats out through a local FIFO.
//
// Ports:
//   clk_i, reset_i          single clock, synchronous active-high reset
//   rd_en_i                 level enable for issuing new bursts
//   pkg_rd_areq/addr/size   burst request (one-cycle pulse, held address)
//   pkg_rd_en/data/last     returned read beats
//   m_data_o/valid_o/ready_i  output stream (valid/ready)
//   xdma_irq_req            one-cycle pulse per consumed buffer (index bit 0)
//   err_o                   sticky protocol error flag
//
// Optional feature: define FDMA_RD_CHECK_EN to enable the beat counter
// and the protocol checker behind err_o. Without it err_o is tied low.

module fdma_rd_ctrl #(
    parameter logic [31:0] ADDR_OFFSET = 32'd0,
    parameter int          BURST_LEN   = 256,
    parameter int          BUF_BURSTS  = 16,
    parameter int          BUF_NUM     = 2,
    parameter int          FIFO_DEPTH  = 512
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         rd_en_i,
    output logic         pkg_rd_areq,
    output logic [31:0]  pkg_rd_addr,
    output logic [31:0]  pkg_rd_size,
    input  logic         pkg_rd_en,
    input  logic [127:0] pkg_rd_data,
    input  logic         pkg_rd_last,
    output logic [127:0] m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [1:0]   xdma_irq_req,
    output logic         err_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int NW = (BUF_NUM > 1) ? $clog2(BUF_NUM) : 1;
    localparam int BW = (BUF_BURSTS > 1) ? $clog2(BUF_BURSTS) : 1;

    localparam logic [CW-1:0] DEPTH_C       = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_C       = CW'(BURST_LEN);
    localparam logic [31:0]   BURST_BYTES_C = 32'(BURST_LEN * 16);
    localparam logic [31:0]   BURSTS_C      = 32'(BUF_BURSTS);
    localparam logic [31:0]   LAST_BUF_C    = 32'(BUF_NUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        REQ,
        DATA,
        NEXT
    } state_e;

    // ------------------------------------------------------------
    // Control FSM state and registered outputs
    // ------------------------------------------------------------
    state_e          state_q;
    logic [NW-1:0]   buf_idx_q;
    logic [BW-1:0]   burst_idx_q;
    logic            areq_q;
    logic [31:0]     addr_q;
    logic [1:0]      irq_q;

    // ------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------
    logic [127:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            space_ok;
    logic [31:0]     addr_d;
    logic [31:0]     burst_nxt;

    assign fifo_full = (cnt_q == DEPTH_C);
    assign pop       = (cnt_q != '0) && m_ready_i;

    // Beats outside DATA are dropped. The full guard only matters for
    // a misbehaving source that sends more beats than were requested.
    assign push = (state_q == DATA) && pkg_rd_en && (!fifo_full || pop);

    // Only stored beats need to be counted: no burst is in flight
    // while the FSM sits in WAIT_SPACE.
    assign space_ok = ((DEPTH_C - cnt_q) >= BURST_C);

    assign addr_d = ADDR_OFFSET
                  + ((32'(buf_idx_q) * BURSTS_C) + 32'(burst_idx_q))
                  * BURST_BYTES_C;

    assign burst_nxt = 32'(burst_idx_q) + 32'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            buf_idx_q   <= '0;
            burst_idx_q <= '0;
            areq_q      <= 1'b0;
            addr_q      <= ADDR_OFFSET;
            irq_q       <= 2'b00;
        end else begin
            areq_q <= 1'b0;
            irq_q  <= 2'b00;
            unique case (state_q)
                IDLE: begin
                    if (rd_en_i) begin
                        state_q <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (!rd_en_i) begin
                        state_q <= IDLE;
                    end else if (space_ok) begin
                        state_q <= REQ;
                        areq_q  <= 1'b1;
                        addr_q  <= addr_d;
                    end
                end
                REQ: begin
                    state_q <= DATA;
                end
                DATA: begin
                    // A dropped rd_en_i is only acted on in NEXT,
                    // so the burst in flight always completes.
                    if (pkg_rd_en && pkg_rd_last) begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (burst_nxt == BURSTS_C) begin
                        burst_idx_q          <= '0;
                        irq_q[buf_idx_q[0]]  <= 1'b1;
                        if (32'(buf_idx_q) == LAST_BUF_C) begin
                            buf_idx_q <= '0;
                        end else begin
                            buf_idx_q <= buf_idx_q + NW'(1);
                        end
                    end else begin
                        burst_idx_q <= BW'(burst_nxt);
                    end
                    state_q <= rd_en_i ? WAIT_SPACE : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pkg_rd_areq  = areq_q;
    assign pkg_rd_addr  = addr_q;
    assign pkg_rd_size  = 32'(BURST_LEN);
    assign xdma_irq_req = irq_q;

    // ------------------------------------------------------------
    // Output FIFO (show-ahead: head entry is presented directly)
    // ------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pkg_rd_data;
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    assign m_valid_o = (cnt_q != '0);
    // Gate with valid so the stream reads as zero when empty.
    assign m_data_o  = m_valid_o ? mem_q[rd_ptr_q] : '0;

    // ------------------------------------------------------------
    // Optional protocol checker
    // ------------------------------------------------------------
`ifdef FDMA_RD_CHECK_EN
    localparam int BCW = $clog2(BURST_LEN + 2);
    localparam logic [BCW-1:0] BL_C  = BCW'(BURST_LEN);
    localparam logic [BCW-1:0] BL1_C = BCW'(BURST_LEN - 1);

    // Counts beats already accepted in the current burst; saturates
    // one past BURST_LEN so an overrun stays visible.
    logic [BCW-1:0] beat_cnt_q;
    logic           err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == REQ) begin
                beat_cnt_q <= '0;
            end else if ((state_q == DATA) && pkg_rd_en
                         && (beat_cnt_q <= BL_C)) begin
                beat_cnt_q <= beat_cnt_q + BCW'(1);
            end
            if (pkg_rd_en) begin
                if (state_q != DATA) begin
                    err_q <= 1'b1;
                end else if (beat_cnt_q >= BL_C) begin
                    err_q <= 1'b1;
                end else if (pkg_rd_last && (beat_cnt_q != BL1_C)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fdma_rd_ctrl.sv
// tb_fdma_rd_ctrl: scoreboard bench for fdma_rd_ctrl with a small
// DDR responder model (BURST_LEN=4, BUF_BURSTS=2, BUF_NUM=2, FIFO_DEPTH=8).

module tb_fdma_rd_ctrl;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         rd_en_i;
    logic         pkg_rd_areq;
    logic [31:0]  pkg_rd_addr;
    logic [31:0]  pkg_rd_size;
    logic         pkg_rd_en;
    logic [127:0] pkg_rd_data;
    logic         pkg_rd_last;
    logic [127:0] m_data_o;
    logic         m_valid_o;
    logic         m_ready_i;
    logic [1:0]   xdma_irq_req;
    logic         err_o;

    fdma_rd_ctrl #(
        .ADDR_OFFSET (32'd0),
        .BURST_LEN   (4),
        .BUF_BURSTS  (2),
        .BUF_NUM     (2),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .rd_en_i      (rd_en_i),
        .pkg_rd_areq  (pkg_rd_areq),
        .pkg_rd_addr  (pkg_rd_addr),
        .pkg_rd_size  (pkg_rd_size),
        .pkg_rd_en    (pkg_rd_en),
        .pkg_rd_data  (pkg_rd_data),
        .pkg_rd_last  (pkg_rd_last),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .xdma_irq_req (xdma_irq_req),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [127:0] sb_q [$];

    int areq_cnt   = 0;
    int exp_buf    = 0;
    int exp_burst  = 0;
    int comp_buf   = 0;
    int comp_burst = 0;
    int irq_cd     = 0;
    logic [1:0] irq_exp = 2'b00;
    logic prev_areq = 1'b0;

    int beats_left = 0;
    int start_dly  = 0;
    bit junk       = 1'b0;
    bit gaps       = 1'b0;
    bit bad_last   = 1'b0;
    int rdy_mode   = 1;
    logic [127:0] seq = '0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_buf    = 0;
        exp_burst  = 0;
        comp_buf   = 0;
        comp_burst = 0;
        irq_cd     = 0;
        irq_exp    = 2'b00;
        sb_q.delete();
    endtask

    // One bench cycle: observe registered outputs at the falling
    // edge, then drive responder and consumer for the next rise.
    task automatic cyc();
        @(negedge clk);
        chk("irq", xdma_irq_req, (irq_cd == 1) ? irq_exp : 2'b00);
        if (irq_cd > 0) irq_cd--;
        if (prev_areq) chk("areq_pulse", pkg_rd_areq, 0);
        prev_areq = pkg_rd_areq;
        if (pkg_rd_areq) begin
            areq_cnt++;
            chk("addr", pkg_rd_addr, 32'((exp_buf * 2 + exp_burst) * 64));
            chk("size", pkg_rd_size, 4);
            exp_burst++;
            if (exp_burst == 2) begin
                exp_burst = 0;
                exp_buf   = (exp_buf + 1) % 2;
            end
            beats_left = bad_last ? 3 : 4;
            start_dly  = 1;
            junk       = 1'b0;
        end
        pkg_rd_en   = 1'b0;
        pkg_rd_last = 1'b0;
        if (start_dly > 0) begin
            start_dly--;
        end else if (beats_left > 0 &&
                     (!gaps || $urandom_range(0, 2) != 0)) begin
            pkg_rd_en   = 1'b1;
            pkg_rd_data = seq;
            pkg_rd_last = (beats_left == 1);
            beats_left--;
            if (!junk) begin
                sb_q.push_back(seq);
                if (pkg_rd_last) begin
                    comp_burst++;
                    irq_cd = 2;
                    if (comp_burst == 2) begin
                        irq_exp    = (comp_buf == 0) ? 2'b01 : 2'b10;
                        comp_burst = 0;
                        comp_buf   = (comp_buf + 1) % 2;
                    end else begin
                        irq_exp = 2'b00;
                    end
                end
            end
            seq++;
        end
        case (rdy_mode)
            0:       m_ready_i = 1'b0;
            1:       m_ready_i = 1'b1;
            default: m_ready_i = 1'($urandom_range(0, 1));
        endcase
        if (m_valid_o && m_ready_i) begin
            if (sb_q.size() == 0) chk("spurious_out", m_valid_o, 0);
            else chk("data", m_data_o, sb_q.pop_front());
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_areq(input int target, input int budget);
        for (int i = 0; i < budget && areq_cnt < target; i++) cyc();
        chk("areq_wait", areq_cnt, target);
    endtask

    int base;

    initial begin
        reset_i     = 1'b1;
        rd_en_i     = 1'b0;
        pkg_rd_en   = 1'b0;
        pkg_rd_data = '0;
        pkg_rd_last = 1'b0;
        m_ready_i   = 1'b1;

        // Reset values
        run(3);
        chk("rst_areq", pkg_rd_areq, 0);
        chk("rst_addr", pkg_rd_addr, 0);
        chk("rst_size", pkg_rd_size, 4);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_data", m_data_o, 0);
        chk("rst_err", err_o, 0);
        reset_i = 1'b0;
        run(3);
        chk("idle_areq", areq_cnt, 0);
        chk("idle_valid", m_valid_o, 0);

        // Ring walk and buffer irqs
        base = areq_cnt;
        rdy_mode = 1;
        rd_en_i  = 1'b1;
        wait_areq(base + 5, 200);
        rd_en_i = 1'b0;
        run(30);
        chk("ring_no_extra", areq_cnt, base + 5);
        chk("ring_drain", sb_q.size(), 0);

        // FIFO backpressure: two bursts fill it, one 4-beat pop frees it
        base = areq_cnt;
        rdy_mode = 0;
        rd_en_i  = 1'b1;
        run(60);
        chk("stall_two", areq_cnt, base + 2);
        rdy_mode = 1;
        run(3);
        rdy_mode = 0;
        run(20);
        chk("stall_three_pops", areq_cnt, base + 2);
        rdy_mode = 1;
        run(1);
        rdy_mode = 0;
        run(30);
        chk("release_third", areq_cnt, base + 3);
        rd_en_i  = 1'b0;
        rdy_mode = 1;
        run(40);
        chk("bp_drain", sb_q.size(), 0);

        // Random ready and beat gaps
        rdy_mode = 2;
        gaps     = 1'b1;
        rd_en_i  = 1'b1;
        run(400);
        rd_en_i = 1'b0;
        run(20);
        rdy_mode = 1;
        run(60);
        gaps = 1'b0;
        chk("rand_drain", sb_q.size(), 0);
        chk("rand_valid", m_valid_o, 0);

        // rd_en_i dropped mid-burst
        base = areq_cnt;
        rd_en_i = 1'b1;
        wait_areq(base + 1, 50);
        run(2);
        rd_en_i = 1'b0;
        run(25);
        chk("drop_no_req", areq_cnt, base + 1);
        chk("drop_drain", sb_q.size(), 0);
        rd_en_i = 1'b1;
        wait_areq(base + 2, 50);
        rd_en_i = 1'b0;
        run(30);

        // Reset in DATA
        base = areq_cnt;
        rd_en_i = 1'b1;
        wait_areq(base + 1, 50);
        run(3);
        reset_i     = 1'b1;
        rd_en_i     = 1'b0;
        pkg_rd_en   = 1'b0;
        pkg_rd_last = 1'b0;
        model_reset();
        beats_left = 2;
        junk       = 1'b1;
        cyc();
        chk("rstdata_valid", m_valid_o, 0);
        reset_i = 1'b0;
        run(6);
        chk("junk_valid", m_valid_o, 0);
`ifdef FDMA_RD_CHECK_EN
        chk("junk_err", err_o, 1);
`else
        chk("junk_err", err_o, 0);
`endif
        rd_en_i = 1'b1;
        wait_areq(base + 2, 50);
        chk("rst_next_addr", pkg_rd_addr, 0);
        rd_en_i = 1'b0;
        run(30);
        chk("rst_drain", sb_q.size(), 0);

`ifdef FDMA_RD_CHECK_EN
        // Short burst: last on beat 3 of 4
        reset_i = 1'b1;
        model_reset();
        run(2);
        reset_i = 1'b0;
        run(1);
        chk("err_cleared", err_o, 0);
        bad_last = 1'b1;
        base     = areq_cnt;
        rd_en_i  = 1'b1;
        wait_areq(base + 1, 50);
        rd_en_i = 1'b0;
        run(20);
        bad_last = 1'b0;
        chk("err_short", err_o, 1);
        run(10);
        chk("err_sticky", err_o, 1);
        reset_i = 1'b1;
        model_reset();
        run(2);
        reset_i = 1'b0;
        run(1);
        chk("err_reset", err_o, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
